ncdf_engine: RTL and testbench

Single-operand standard normal CDF engine: on a one-cycle `start` pulse it samples a signed fixed-point argument `d`, evaluates N(d) with a piecewise-quadratic approximation over a fixed-latency sequential datapath, and returns the result with a one-cycle `done` pulse. It is the responder side of the start/done handshake used by the Black-Scholes pricing sequencer. The sequencer instantiates one engine per d-term and waits on `done` before consuming `N`.

---
 rtl/ncdf_pkg.sv | 41 ++++
 rtl/ncdf_coef_rom.sv | 15 +
 rtl/ncdf_engine.sv | 149 ++++++++++++++
 tb/tb_ncdf_engine.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ncdf_pkg.sv
// Shared types and constants for the standard normal CDF engine.
// Coefficients are Q.16 least-squares quadratic fits of N(x) over [0.25i, 0.25i+0.25).
package ncdf_pkg;

    localparam int unsigned SEG_BITS  = 4;
    localparam int unsigned SEG_NUM   = 1 << SEG_BITS;
    localparam int unsigned COEF_W    = 32;
    localparam int unsigned COEF_FRAC = 16;
    localparam logic [31:0] SAT_LIMIT = 32'(4 << COEF_FRAC);

    typedef enum logic [2:0] {
        IDLE,
        SEG,
        H1,
        H2,
        FIX
    } state_t;

    typedef logic signed [COEF_W-1:0] coef_word_t;

    typedef struct packed {
        coef_word_t c2;
        coef_word_t c1;
        coef_word_t c0;
    } coef_t;

    // p(t) = c2*t^2 + c1*t + c0, with t the offset inside the segment
    localparam coef_word_t C2_TAB [SEG_NUM] = '{
        -1621, -4569, -6721, -7800, -7811, -6984, -5673, -4226,
        -2905, -1850, -1094,  -603,  -309,  -148,   -66,   -28
    };
    localparam coef_word_t C1_TAB [SEG_NUM] = '{
        26307, 25480, 23166, 19773, 15844, 11919,  8418,  5582,
         3475,  2032,  1115,   575,   278,   126,    54,    22
    };
    localparam coef_word_t C0_TAB [SEG_NUM] = '{
        32765, 39234, 45314, 50683, 55139, 58613, 61159, 62912,
        64046, 64736, 65130, 65341, 65448, 65498, 65521, 65530
    };

endpackage

// File: rtl/ncdf_coef_rom.sv
// Combinational coefficient lookup for one 0.25-wide segment of |d|.
module ncdf_coef_rom
    import ncdf_pkg::*;
(
    input  logic [SEG_BITS-1:0] idx,
    output coef_t               coef_c
);

    always_comb begin
        coef_c.c2 = C2_TAB[idx];
        coef_c.c1 = C1_TAB[idx];
        coef_c.c0 = C0_TAB[idx];
    end

endmodule

// File: rtl/ncdf_engine.sv
// Standard normal CDF engine: start/done responder, fixed 4-cycle latency,
// piecewise-quadratic Horner evaluation on one shared multiplier.
module ncdf_engine
    import ncdf_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] d,
    output logic signed [WIDTH-1:0] N,
    output logic                    done,
    output logic                    busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_nxt;
    logic   done_nxt, busy_nxt;

    logic signed [WIDTH-1:0] d_r, t_r, acc_r;
    logic signed [WIDTH-1:0] c2_r, c1_r, c0_r;
    logic                    neg_r, sat_r;

    logic [WIDTH-1:0]        mag_c;
    logic                    sat_c;
    logic [SEG_BITS-1:0]     idx_c;
    coef_t                   coef_c;
    logic signed [WIDTH-1:0] mul_a_c, add_c, mac_c, p_c, clamp_c;
    logic signed [PW-1:0]    prod_c, shf_c, sum_c;

    // |d| with the most negative input pinned to the largest positive value
    always_comb begin
        if (d_r == MIN_NEG)
            mag_c = MAX_POS;
        else if (d_r[WIDTH-1])
            mag_c = -d_r;
        else
            mag_c = d_r;
        sat_c = (mag_c >= WIDTH'(SAT_LIMIT));
        idx_c = mag_c[FRAC+1:FRAC-2];
    end

    ncdf_coef_rom u_rom (
        .idx    (idx_c),
        .coef_c (coef_c)
    );

    // Shared multiply-add: H1 folds c2 into c1, H2 folds acc into c0
    always_comb begin
        mul_a_c = (state == H1) ? c2_r : acc_r;
        add_c   = (state == H1) ? c1_r : c0_r;
        prod_c  = PW'(mul_a_c) * PW'(t_r);
        shf_c   = prod_c >>> FRAC;
        sum_c   = shf_c + PW'(add_c);
        if (sum_c > PW'(MAX_POS))
            mac_c = MAX_POS;
        else if (sum_c < PW'(MIN_NEG))
            mac_c = MIN_NEG;
        else
            mac_c = WIDTH'(sum_c);
    end

    always_comb begin
        p_c = sat_r ? ONE : acc_r;
        if (p_c < 0)
            clamp_c = '0;
        else if (p_c > ONE)
            clamp_c = ONE;
        else
            clamp_c = p_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SEG;
            SEG: begin
                state_nxt = H1;
                busy_nxt  = 1'b1;
            end
            H1: begin
                state_nxt = H2;
                busy_nxt  = 1'b1;
            end
            H2: begin
                state_nxt = FIX;
                busy_nxt  = 1'b1;
            end
            FIX: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b1;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_r   <= '0;
            t_r   <= '0;
            acc_r <= '0;
            c2_r  <= '0;
            c1_r  <= '0;
            c0_r  <= '0;
            neg_r <= 1'b0;
            sat_r <= 1'b0;
            N     <= '0;
        end else begin
            case (state)
                IDLE: d_r <= d;
                SEG: begin
                    neg_r <= d_r[WIDTH-1];
                    sat_r <= sat_c;
                    t_r   <= WIDTH'(mag_c[FRAC-3:0]);
                    if (!sat_c) begin
                        c2_r <= WIDTH'(coef_c.c2);
                        c1_r <= WIDTH'(coef_c.c1);
                        c0_r <= WIDTH'(coef_c.c0);
                    end
                end
                H1, H2: acc_r <= mac_c;
                FIX: N <= neg_r ? (ONE - clamp_c) : clamp_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ncdf_engine.sv
// Directed bench for ncdf_engine: latency, accuracy, symmetry, saturation,
// start-while-busy and mid-request reset.
module tb_ncdf_engine;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [31:0] d;
    logic signed [31:0] n;
    logic               done;
    logic               busy;

    int total = 0;
    int bad   = 0;

    ncdf_engine #(.WIDTH(32), .FRAC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .d     (d),
        .N     (n),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
        total++;
        if (got < exp - tol || got > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Accept one request and wait (bounded) for done; lat=0 means it never came
    task automatic run_op(input logic signed [31:0] dv, output int res, output int lat,
                          output logic b_first, output logic b_done);
        start = 1'b1;
        d     = dv;
        @(posedge clk); #1;
        start   = 1'b0;
        d       = 32'sh5a5a5a5a;
        lat     = 0;
        res     = 0;
        b_first = 1'b0;
        b_done  = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) b_first = busy;
            if (done && lat == 0) begin
                lat    = c;
                res    = n;
                b_done = busy;
                break;
            end
        end
    endtask

    task automatic op_check(input string tag, input logic signed [31:0] dv,
                            input int exp, input int tol, output int res);
        int   lat;
        logic b1, bd;
        run_op(dv, res, lat, b1, bd);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_n"}, res, exp, tol);
        chk({tag, "_busy1"}, b1, 1);
        chk({tag, "_busyd"}, bd, 1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int np, nn, r, mask, n4, n9, dcount;

        reset = 1'b1;
        start = 1'b0;
        d     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_n", n, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("idle_n", n, 0);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
        end

        op_check("d0", 32'sd0, 32768, 8, r);
        op_check("d1p", 32'sd65536, 55138, 8, np);
        op_check("d1n", -32'sd65536, 10398, 8, nn);
        chk("sym", np + nn, 65536);
        op_check("dhalf", 32'sd32768, 45316, 8, r);
        repeat (3) @(posedge clk);
        #1;
        chk("hold", n, 45316, 8);
        op_check("dtenth", 32'sd6554, 35378, 8, r);
        op_check("d2", 32'sd131072, 64045, 8, r);
        op_check("dbelow4", 32'sd262143, 65534, 8, r);
        op_check("d4", 32'sd262144, 65536, 0, r);
        op_check("dsat_p", 32'sd327680, 65536, 0, r);
        op_check("dsat_n", -32'sd327680, 0, 0, r);
        op_check("dmin", 32'sh80000000, 0, 0, r);

        // start re-pulsed while busy, then a fresh request at k+5
        start = 1'b1;
        d     = 32'sd65536;
        @(posedge clk);
        mask = 0;
        n4   = -1;
        n9   = -1;
        for (int e = 1; e <= 9; e++) begin
            #1;
            case (e)
                1: begin start = 1'b1; d = 32'sd327680; end
                2: d = -32'sd327680;
                3: d = 32'sh80000000;
                4: start = 1'b0;
                5: begin start = 1'b1; d = 32'sd0; end
                default: start = 1'b0;
            endcase
            @(posedge clk); #1;
            if (done) mask |= (1 << e);
            if (e == 4) n4 = n;
            if (e == 9) n9 = n;
        end
        chk("rp_mask", mask, 32'h210);
        chk("rp_n4", n4, 55138, 8);
        chk("rp_n9", n9, 32768, 8);

        // reset lands in the middle of a request
        start = 1'b1;
        d     = 32'sd65536;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mrst_n", n, 0);
        chk("mrst_busy", busy, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("mrst_nodone", dcount, 0);
        chk("mrst_n_after", n, 0);
        op_check("post_rst", 32'sd0, 32768, 8, r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
